// File: rtl/vga_term_ctrl_if.sv
// Keyboard byte handshake plus the single-cell vmem write port of the terminal controller.
// key_valid/key_data are driven by the source; a byte transfers on any cycle where key_valid && key_ready; vmem_we writes one cell per cycle.
interface vga_term_ctrl_if #(
  parameter int COL_W = 7,
  parameter int ROW_W = 5
);
  logic                   key_valid;
  logic [7:0]             key_data;
  logic                   key_ready;
  logic                   vmem_we;
  logic [COL_W+ROW_W-1:0] vmem_waddr;
  logic [7:0]             vmem_wdata;

  // master: keyboard side / vmem observer; slave: the terminal controller
  modport master (
    output key_valid, key_data,
    input  key_ready, vmem_we, vmem_waddr, vmem_wdata
  );
  modport slave (
    input  key_valid, key_data,
    output key_ready, vmem_we, vmem_waddr, vmem_wdata
  );
endinterface

// File: rtl/vga_term_ctrl.sv
// Terminal controller owning the text vmem write port: cursor, LF/CR, backspace, wrap, scroll via scroll_base.
// Optional feature macro: CURSOR_BLINK_EN (cursor_on blinks every BLINK_DIV cycles; otherwise tied to 1).
module vga_term_ctrl #(
  parameter int COLS      = 70,
  parameter int ROWS      = 30,
  parameter int COL_W     = 7,
  parameter int ROW_W     = 5,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic               clk,
  input  logic               rst,
  vga_term_ctrl_if.slave     bus,
  output logic [COL_W-1:0]   cur_col,
  output logic [ROW_W-1:0]   cur_row,
  output logic [ROW_W-1:0]   scroll_base,
  output logic               cursor_on,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    EXEC     = 2'd2,
    CLR_LINE = 2'd3
  } state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] ONE_C    = COL_W'(1);
  localparam logic [ROW_W-1:0] ONE_R    = ROW_W'(1);
  localparam logic [ROW_W:0]   ROWS_EXT = (ROW_W+1)'(ROWS);
  localparam logic [7:0]       SPACE    = 8'h20;

  state_t                   state_q, state_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [ROW_W-1:0]         base_q, base_d;
  logic                     ready_q, ready_d;
  logic                     we_q, we_d;
  logic [COL_W+ROW_W-1:0]   waddr_q, waddr_d;
  logic [7:0]               wdata_q, wdata_d;
  logic [COL_W-1:0]         clr_col_q, clr_col_d;
  logic [ROW_W-1:0]         clr_row_q, clr_row_d;
  logic                     scroll_q, scroll_d;
  logic                     accept;
  logic                     newline;
  logic [ROW_W-1:0]         cur_prow;

  function automatic logic [ROW_W-1:0] phys(input logic [ROW_W-1:0] r, input logic [ROW_W-1:0] b);
    logic [ROW_W:0] s;
    s = {1'b0, r} + {1'b0, b};
    if (s >= ROWS_EXT) s = s - ROWS_EXT;
    return s[ROW_W-1:0];
  endfunction

  assign accept   = (state_q == IDLE) && bus.key_valid && ready_q;
  assign cur_prow = phys(row_q, base_q);

  // The byte is decoded in the acceptance cycle so its write lands in the EXEC cycle.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    base_d    = base_q;
    ready_d   = 1'b0;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    clr_col_d = clr_col_q;
    clr_row_d = clr_row_q;
    scroll_d  = scroll_q;
    newline   = 1'b0;

    case (state_q)
      CLR_ALL: begin
        we_d    = 1'b1;
        waddr_d = {clr_col_q, clr_row_q};
        wdata_d = SPACE;
        if (clr_row_q == LAST_ROW) begin
          clr_row_d = '0;
          if (clr_col_q == LAST_COL) begin
            clr_col_d = '0;
            state_d   = IDLE;
            ready_d   = 1'b1;
          end else begin
            clr_col_d = clr_col_q + ONE_C;
          end
        end else begin
          clr_row_d = clr_row_q + ONE_R;
        end
      end

      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d  = 1'b0;
          state_d  = EXEC;
          scroll_d = 1'b0;
          if (bus.key_data >= 8'h20 && bus.key_data <= 8'h7E) begin
            we_d    = 1'b1;
            waddr_d = {col_q, cur_prow};
            wdata_d = bus.key_data;
            if (col_q == LAST_COL) begin
              col_d   = '0;
              newline = 1'b1;
            end else begin
              col_d = col_q + ONE_C;
            end
          end else if (bus.key_data == 8'h0A || bus.key_data == 8'h0D) begin
            col_d   = '0;
            newline = 1'b1;
          end else if (bus.key_data == 8'h08) begin
            if (col_q != '0) begin
              col_d   = col_q - ONE_C;
              we_d    = 1'b1;
              waddr_d = {col_q - ONE_C, cur_prow};
              wdata_d = SPACE;
            end else if (row_q != '0) begin
              row_d   = row_q - ONE_R;
              col_d   = LAST_COL;
              we_d    = 1'b1;
              waddr_d = {LAST_COL, phys(row_q - ONE_R, base_q)};
              wdata_d = SPACE;
            end
          end

          if (newline) begin
            if (row_q != LAST_ROW) begin
              row_d = row_q + ONE_R;
            end else begin
              base_d    = (base_q == LAST_ROW) ? '0 : base_q + ONE_R;
              scroll_d  = 1'b1;
              clr_row_d = phys(LAST_ROW, base_d);
            end
          end
        end
      end

      EXEC: begin
        if (scroll_q) begin
          state_d   = CLR_LINE;
          we_d      = 1'b1;
          waddr_d   = {{COL_W{1'b0}}, clr_row_q};
          wdata_d   = SPACE;
          clr_col_d = '0;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end

      CLR_LINE: begin
        // Each CLR_LINE cycle shows the write issued on entry to it, so key_ready stays low for all COLS writes.
        if (clr_col_q == LAST_COL) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          clr_col_d = clr_col_q + ONE_C;
          we_d      = 1'b1;
          waddr_d   = {clr_col_q + ONE_C, clr_row_q};
          wdata_d   = SPACE;
        end
      end

      default: state_d = CLR_ALL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLR_ALL;
      col_q     <= '0;
      row_q     <= '0;
      base_q    <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= SPACE;
      clr_col_q <= '0;
      clr_row_q <= '0;
      scroll_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      base_q    <= base_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      clr_col_q <= clr_col_d;
      clr_row_q <= clr_row_d;
      scroll_q  <= scroll_d;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt;
  logic          cursor_q;

  // Typing restarts the blink phase so the cursor is solid while keys arrive.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      blink_cnt <= '0;
      cursor_q  <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      cursor_q  <= ~cursor_q;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign cursor_on = cursor_q;
`else
  assign cursor_on = 1'b1;
`endif

  assign bus.key_ready  = ready_q;
  assign bus.vmem_we    = we_q;
  assign bus.vmem_waddr = waddr_q;
  assign bus.vmem_wdata = wdata_q;
  assign cur_col        = col_q;
  assign cur_row        = row_q;
  assign scroll_base    = base_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_vga_term_ctrl.sv
// Bench for vga_term_ctrl: screen-level reference model feeds an expected-write queue drained by a vmem monitor.
module tb_vga_term_ctrl;
  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int COL_W = 7;
  localparam int ROW_W = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic [ROW_W-1:0] scroll_base;
  logic             cursor_on;
  logic [1:0]       state_dbg;

  vga_term_ctrl_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

  vga_term_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .BLINK_DIV(12_500_000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cur_col(cur_col),
    .cur_row(cur_row),
    .scroll_base(scroll_base),
    .cursor_on(cursor_on),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [COL_W+ROW_W+7:0] exp_q[$];

  int m_col, m_row, m_base;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic int phys(input int r);
    return (r + m_base) % ROWS;
  endfunction

  function automatic void push_w(input int c, input int r, input logic [7:0] d);
    exp_q.push_back({COL_W'(c), ROW_W'(r), d});
  endfunction

  // Screen-level meaning of one byte: cells it writes, whether a write shows the next cycle, whether it scrolls.
  function automatic void model_apply(input logic [7:0] b, output bit we_now, output bit scrolled);
    bit nl;
    we_now = 0; scrolled = 0; nl = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_w(m_col, phys(m_row), b);
      we_now = 1;
      if (m_col == COLS - 1) begin m_col = 0; nl = 1; end
      else m_col++;
    end else if (b == 8'h0A || b == 8'h0D) begin
      m_col = 0; nl = 1;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--; push_w(m_col, phys(m_row), 8'h20); we_now = 1;
      end else if (m_row > 0) begin
        m_row--; m_col = COLS - 1; push_w(m_col, phys(m_row), 8'h20); we_now = 1;
      end
    end
    if (nl) begin
      if (m_row < ROWS - 1) m_row++;
      else begin
        m_base = (m_base + 1) % ROWS;
        scrolled = 1;
        for (int c = 0; c < COLS; c++) push_w(c, phys(ROWS - 1), 8'h20);
      end
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.vmem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write got=0x%0h exp=none", {bus.vmem_waddr, bus.vmem_wdata});
      end else begin
        check("vmem_write", {bus.vmem_waddr, bus.vmem_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (bus.key_ready !== 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.key_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout got=0 exp=1 after=%0d", n);
    end
  endtask

  task automatic check_cursor();
    check("cur_col", cur_col, m_col);
    check("cur_row", cur_row, m_row);
    check("scroll_base", scroll_base, m_base);
    check("cursor_on", cursor_on, 1);
  endtask

  task automatic do_reset();
    int n;
    rst = 1'b1;
    bus.key_valid = 1'b0;
    exp_q.delete();
    m_col = 0; m_row = 0; m_base = 0;
    @(posedge clk); #1;
    check("rst_ready", bus.key_ready, 0);
    check("rst_we", bus.vmem_we, 0);
    check("rst_waddr", bus.vmem_waddr, 0);
    check("rst_wdata", bus.vmem_wdata, 8'h20);
    check_cursor();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) push_w(c, r, 8'h20);
    rst = 1'b0;
    wait_ready(3000, n);
    check("clear_len", n, COLS * ROWS);
    @(negedge clk); #1;
    check("clear_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit we_now, scr;
    int n;
    wait_ready(200, n);
    bus.key_valid = 1'b1;
    bus.key_data  = b;
    model_apply(b, we_now, scr);
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    bus.key_data  = 8'($urandom);
    check("ready_drop", bus.key_ready, 0);
    check("exec_we", bus.vmem_we, we_now);
    wait_ready(200, n);
    check("ready_latency", n, scr ? COLS + 1 : 1);
    check_cursor();
  endtask

  function automatic logic [7:0] rand_byte();
    int p;
    p = $urandom_range(0, 99);
    if (p < 70) return 8'($urandom_range(32, 126));
    if (p < 75) return 8'h0A;
    if (p < 78) return 8'h0D;
    if (p < 92) return 8'h08;
    return 8'($urandom_range(127, 255));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bus.key_valid = 1'b0;
    bus.key_data  = 8'h00;
    do_reset();

    send(8'h42);
    send(8'h08);
    repeat (COLS) send(8'h41);

    send(8'h08);
    repeat (COLS - 1) send(8'h08);
    send(8'h08);

    while (m_row < ROWS - 1) send(8'h0A);
    repeat (ROWS + 1) send(8'h0A);

    repeat (300) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(rand_byte());
    end

    begin
      int n;
      bit we_now, scr;
      while (m_row < ROWS - 1) send(8'h0A);
      wait_ready(200, n);
      bus.key_valid = 1'b1;
      bus.key_data  = 8'h0A;
      model_apply(8'h0A, we_now, scr);
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      check("mid_clr_line_ready", bus.key_ready, 0);
      do_reset();
    end

    repeat (20) send(rand_byte());

    @(negedge clk); #1;
    check("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
